// File: rtl/dbus_pkg.sv
// Shared constants and types for the data-side bus: IO decode,
// register offsets, STATUS bit positions and the UART TX states.
package dbus_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [2:0] OFF_LEDS   = 3'd0;
    localparam logic [2:0] OFF_TXDATA = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CYCLES = 3'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/dbus_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter: circular byte FIFO with a sticky
// overflow flag, feeding a start/data/stop serialiser with no inter-frame gap.
module dbus_uart_tx
    import dbus_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     clr_ovf,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [7:0]    fifo [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;

    tx_state_t     state;
    tx_state_t     state_nx;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          pop;
    logic          tick;
    logic          do_push;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign busy    = (state != TX_IDLE);
    assign tick    = (baud == BW'(CLKS_PER_BIT - 1));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign do_push = push && (!full || pop);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            TX_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = TX_START;
                end
            end
            TX_START: begin
                if (tick) state_nx = TX_DATA;
            end
            TX_DATA: begin
                if (tick && bit_cnt == 3'd7) state_nx = TX_STOP;
            end
            TX_STOP: begin
                if (tick) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = TX_START;
                    end else begin
                        state_nx = TX_IDLE;
                    end
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
            else if (clr_ovf)         ovf <= 1'b0;
        end
    end

    // Every exit from a non-idle state happens on a tick, so clearing
    // on tick also restarts the baud count at each state entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nx;
            if (state == TX_IDLE || tick) baud <= '0;
            else                          baud <= baud + 1'b1;
            if (state == TX_START)            bit_cnt <= '0;
            else if (state == TX_DATA && tick) bit_cnt <= bit_cnt + 1'b1;
            if (pop)                           shreg <= fifo[rd_ptr];
            else if (state == TX_DATA && tick) shreg <= {1'b0, shreg[7:1]};
        end
    end

endmodule

// File: rtl/riscv_data_bus.sv
// Data-side memory system: word RAM plus IO (LEDs, STATUS, UART TX, CYCLES).
// Define DBUS_CYCLE_COUNTER_EN to build the free-running cycle counter.
module riscv_data_bus
  import dbus_pkg::*;
#(
  parameter int DMEM_WORDS    = 1024,
  parameter     DMEM_INIT     = "",
  parameter int TX_FIFO_DEPTH = 8,
  parameter int CLKS_PER_BIT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_off;
  logic          is_io;
  logic          io_wr;
  logic          push;
  logic          clr_ovf;
  logic          tx_busy;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_ovf;
  logic [CW-1:0] tx_count;
  logic [31:0]   status;
  logic [31:0]   cycles;
  logic          unused_bits;

  assign unused_bits = ^{Address, WriteData};

  assign is_io   = Address[IO_SEL_BIT];
  assign io_off  = Address[4:2];
  assign ram_idx = Address[AW+1:2];
  assign io_wr   = MemWrite && is_io;
  assign push    = io_wr
                && (io_off == OFF_TXDATA);
  assign clr_ovf = io_wr
                && (io_off == OFF_STATUS)
                && WriteData[ST_OVF];

  always_ff @(posedge clk) begin
    if (MemWrite && !is_io)
      mem[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      leds <= '0;
    else if (io_wr && io_off == OFF_LEDS)
      leds <= WriteData[7:0];
  end

`ifdef DBUS_CYCLE_COUNTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycles <= '0;
    else        cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif

  dbus_uart_tx #(
    .DEPTH        (TX_FIFO_DEPTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (WriteData[7:0]),
    .clr_ovf   (clr_ovf),
    .tx        (uart_tx),
    .busy      (tx_busy),
    .full      (tx_full),
    .empty     (tx_empty),
    .ovf       (tx_ovf),
    .count     (tx_count)
  );

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = tx_busy;
    status[ST_FULL]  = tx_full;
    status[ST_EMPTY] = tx_empty;
    status[ST_OVF]   = tx_ovf;
    status[15:8]     = 8'(tx_count);
  end

  always_comb begin
    ReadData = '0;
    if (!is_io) begin
      ReadData = mem[ram_idx];
    end else begin
      case (io_off)
        OFF_LEDS:   ReadData = {24'd0, leds};
        OFF_STATUS: ReadData = status;
        OFF_CYCLES: ReadData = cycles;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_data_bus.sv
// Directed self-checking bench for riscv_data_bus (CLKS_PER_BIT=4, depth 8).
module tb_riscv_data_bus;

    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_TX     = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_CYC    = 32'h0040_000C;
    localparam logic [31:0] A_OFF5   = 32'h0040_0014;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        uart_tx;

    int tests;
    int fails;

    riscv_data_bus #(
        .DMEM_WORDS    (1024),
        .DMEM_INIT     (""),
        .TX_FIFO_DEPTH (8),
        .CLKS_PER_BIT  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level at cycle q-slot of a frame (slot = 4 clocks).
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        Address = a;
        #1 d = ReadData;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        tests++;
        if (uart_tx !== 1'b1 || leds !== 8'h00) begin
            fails++;
            $display("FAIL reset_pins: tx=%b leds=%h, want tx=1 leds=00", uart_tx, leds);
        end
        load(A_STATUS, v);
        tests++;
        if (v !== 32'h0000_0004) begin
            fails++;
            $display("FAIL reset_status: got %h want 00000004", v);
        end
        load(A_LEDS, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL reset_leds_rd: got %h want 00000000", v);
        end
    endtask

    task automatic test_ram;
        logic [31:0] v;
        store(32'h100, 32'hDEAD_BEEF);
        load(32'h100, v);
        tests++;
        if (v !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ram_rw: got %h want deadbeef", v);
        end
        store(32'h100 + 32'd4096, 32'hCAFE_F00D);
        load(32'h103, v);
        tests++;
        if (v !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL ram_alias: got %h want cafef00d", v);
        end
    endtask

    task automatic test_same_cycle;
        store(32'h40, 32'hAAAA_5555);
        @(negedge clk);
        Address   = 32'h40;
        WriteData = 32'h1;
        MemWrite  = 1'b1;
        #1;
        tests++;
        if (ReadData !== 32'hAAAA_5555) begin
            fails++;
            $display("FAIL same_cycle_old: got %h want aaaa5555", ReadData);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        tests++;
        if (ReadData !== 32'h1) begin
            fails++;
            $display("FAIL same_cycle_new: got %h want 00000001", ReadData);
        end
    endtask

    task automatic test_uart;
        int bad_tx;
        int bad_busy;
        store(A_TX, 32'hA5);
        Address = A_STATUS;
        #1;
        tests++;
        if (uart_tx !== 1'b1 || ReadData !== 32'h0000_0100) begin
            fails++;
            $display("FAIL uart_pre: tx=%b status=%h want tx=1 status=00000100", uart_tx, ReadData);
        end
        bad_tx   = 0;
        bad_busy = 0;
        for (int p = 0; p < 40; p++) begin
            @(negedge clk);
            if (uart_tx !== exp_bit(8'hA5, p / 4)) bad_tx++;
            if (ReadData[0] !== 1'b1) bad_busy++;
        end
        tests++;
        if (bad_tx != 0 || bad_busy != 0) begin
            fails++;
            $display("FAIL uart_frame: tx errors %0d busy errors %0d want 0", bad_tx, bad_busy);
        end
        @(negedge clk);
        tests++;
        if (uart_tx !== 1'b1 || ReadData !== 32'h0000_0004) begin
            fails++;
            $display("FAIL uart_post: tx=%b status=%h want tx=1 status=00000004", uart_tx, ReadData);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] bytes [10];
        int bad_tx;
        int bad_busy;
        for (int k = 0; k < 10; k++) bytes[k] = 8'h30 + 8'(k * 7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            Address   = A_TX;
            WriteData = {24'd0, bytes[k]};
            MemWrite  = 1'b1;
        end
        @(negedge clk);
        MemWrite = 1'b0;
        Address  = A_STATUS;
        #1;
        tests++;
        if (ReadData !== 32'h0000_080B) begin
            fails++;
            $display("FAIL ovf_status: got %h want 0000080b", ReadData);
        end
        Address   = A_STATUS;
        WriteData = 32'h8;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        tests++;
        if (ReadData !== 32'h0000_0803) begin
            fails++;
            $display("FAIL ovf_clear: got %h want 00000803", ReadData);
        end
        bad_tx   = 0;
        bad_busy = 0;
        for (int p = 9; p < 360; p++) begin
            if (p != 9) @(negedge clk);
            if (uart_tx !== exp_bit(bytes[p / 40], (p % 40) / 4)) bad_tx++;
            if (ReadData[0] !== 1'b1) bad_busy++;
        end
        tests++;
        if (bad_tx != 0 || bad_busy != 0) begin
            fails++;
            $display("FAIL ovf_stream: tx errors %0d busy errors %0d want 0", bad_tx, bad_busy);
        end
        @(negedge clk);
        tests++;
        if (uart_tx !== 1'b1 || ReadData !== 32'h0000_0004) begin
            fails++;
            $display("FAIL ovf_drain: tx=%b status=%h want tx=1 status=00000004", uart_tx, ReadData);
        end
    endtask

    task automatic test_reset_midframe;
        int bad;
        store(A_LEDS, 32'h55);
        store(A_TX, 32'hA5);
        Address = A_STATUS;
        repeat (18) @(negedge clk);
        tests++;
        if (uart_tx !== 1'b0 || leds !== 8'h55) begin
            fails++;
            $display("FAIL pre_reset_bit3: tx=%b leds=%h want tx=0 leds=55", uart_tx, leds);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (uart_tx !== 1'b1 || leds !== 8'h00 || ReadData !== 32'h0000_0004) begin
            fails++;
            $display("FAIL midframe_reset: tx=%b leds=%h status=%h want 1/00/00000004",
                     uart_tx, leds, ReadData);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_byte_lost: tx low on %0d cycles want 0", bad);
        end
    endtask

    task automatic test_leds_cycles;
        logic [31:0] v;
        logic [31:0] c0;
        logic [31:0] c1;
        store(A_LEDS, 32'h1FF);
        load(A_LEDS, v);
        tests++;
        if (leds !== 8'hFF || v !== 32'h0000_00FF) begin
            fails++;
            $display("FAIL leds_write: leds=%h read=%h want ff/000000ff", leds, v);
        end
        store(A_OFF5, 32'hFFFF_FFFF);
        load(A_OFF5, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL off5_read: got %h want 00000000", v);
        end
        load(A_TX, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL txdata_read: got %h want 00000000", v);
        end
        store(A_CYC, 32'h1234_5678);
        load(A_CYC, c0);
        repeat (5) @(negedge clk);
        #1 c1 = ReadData;
        tests++;
`ifdef DBUS_CYCLE_COUNTER_EN
        if (c1 - c0 !== 32'd5 || c0 == 32'h1234_5678) begin
            fails++;
            $display("FAIL cycles_delta: c0=%h c1=%h want difference 5", c0, c1);
        end
`else
        if (c0 !== 32'h0 || c1 !== 32'h0) begin
            fails++;
            $display("FAIL cycles_off: c0=%h c1=%h want 0/0", c0, c1);
        end
`endif
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_ram();
        test_same_cycle();
        test_uart();
        test_overflow();
        test_reset_midframe();
        test_leds_cycles();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
